// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op, flag and sequencer state types
package alu_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SHR, OP_LDUI} alu_op_e;
  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } alu_flags_t;
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_e;
  // s2[15] selects left shifts, encoded as a two's-complement count in s2[3:0]
  function automatic logic [3:0] shift_amt(input logic [15:0] s2);
    return s2[15] ? 4'(4'd0 - s2[3:0]) : s2[3:0];
  endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational 16-bit ALU for the non-shift ops with {z,c,n,v} flags
module alu
  import alu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] d_o,
  output alu_flags_t  flags_o
);
  logic [16:0] add_r;
  logic [16:0] sub_r;
  assign add_r = {1'b0, a_i} + {1'b0, b_i};
  assign sub_r = {1'b0, a_i} + {1'b0, ~b_i} + 17'd1;
  // result mux and flags; SUB carry means no borrow, unknown ops yield zero
  always_comb begin
    d_o = op_i == OP_ADD ? add_r[15:0] : op_i == OP_SUB ? sub_r[15:0] : op_i == OP_AND ? a_i & b_i :
          op_i == OP_XOR ? a_i ^ b_i : op_i == OP_LDUI ? {b_i[7:0], 8'h00} : 16'h0000;
    flags_o.z = d_o == 16'h0000;
    flags_o.n = d_o[15];
    flags_o.c = op_i == OP_ADD ? add_r[16] : op_i == OP_SUB && sub_r[16];
    flags_o.v = op_i == OP_ADD ? (a_i[15] == b_i[15]) && (add_r[15] != a_i[15]) :
                op_i == OP_SUB && (a_i[15] != b_i[15]) && (sub_r[15] != a_i[15]);
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: request/response wrapper around the ALU with a bit-serial shifter
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int RD_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [15:0]     req_s1,
  input  logic [15:0]     req_s2,
  input  logic [RD_W-1:0] req_rd,
  input  logic            req_setflags,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [15:0]     rsp_d,
  output logic [RD_W-1:0] rsp_rd,
  output alu_flags_t      flags
);
  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [15:0]     s1_q, s1_d, s2_q, s2_d;
  logic [RD_W-1:0] rd_q, rd_d, rsp_rd_q, rsp_rd_d;
  logic            setf_q, setf_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     rsp_d_q, rsp_d_d;
  alu_flags_t      flags_q, flags_d;
  logic [15:0]     alu_d;
  alu_flags_t      alu_f;
  logic [3:0]      amt;
  logic [15:0]     sh_d;
  logic            sh_c;
  alu u_alu (
    .op_i   (op_q),
    .a_i    (s1_q),
    .b_i    (s2_q),
    .d_o    (alu_d),
    .flags_o(alu_f)
  );
  assign amt       = shift_amt(req_s2);
  assign sh_d      = s2_q[15] ? {s1_q[14:0], 1'b0} : {1'b0, s1_q[15:1]};
  assign sh_c      = s2_q[15] ? s1_q[15] : s1_q[0];
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_d     = rsp_d_q;
  assign rsp_rd    = rsp_rd_q;
  assign flags     = flags_q;
  // next state; result and flags are captured on the transition into RESP
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    rd_d     = rd_q;
    setf_d   = setf_q;
    cnt_d    = cnt_q;
    rsp_d_d  = rsp_d_q;
    rsp_rd_d = rsp_rd_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: if (req_valid) begin
        op_d   = req_op;
        s1_d   = req_s1;
        s2_d   = req_s2;
        rd_d   = req_rd;
        setf_d = req_setflags;
        if (req_op != OP_SHR) state_d = EXEC;
        else if (amt != 4'd0) begin
          state_d = SHIFT;
          cnt_d   = amt;
        end else begin
          state_d  = RESP;
          rsp_d_d  = req_s1;
          rsp_rd_d = req_rd;
          flags_d  = req_setflags ? alu_flags_t'({req_s1 == 16'h0000, 1'b0, req_s1[15], 1'b0}) : flags_q;
        end
      end
      EXEC: begin
        state_d  = RESP;
        rsp_d_d  = alu_d;
        rsp_rd_d = rd_q;
        flags_d  = setf_q ? alu_f : flags_q;
      end
      SHIFT: begin
        s1_d  = sh_d;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = RESP;
          rsp_d_d  = sh_d;
          rsp_rd_d = rd_q;
          flags_d  = setf_q ? alu_flags_t'({sh_d == 16'h0000, sh_c, sh_d[15], 1'b0}) : flags_q;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state register; reset drops any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      s1_q     <= 16'h0000;
      s2_q     <= 16'h0000;
      rd_q     <= '0;
      setf_q   <= 1'b0;
      cnt_q    <= 4'd0;
      rsp_d_q  <= 16'h0000;
      rsp_rd_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      rd_q     <= rd_d;
      setf_q   <= setf_d;
      cnt_q    <= cnt_d;
      rsp_d_q  <= rsp_d_d;
      rsp_rd_q <= rsp_rd_d;
      flags_q  <= flags_d;
    end
  end
endmodule
